// File: rtl/usb_rx_buffer_ctrl.sv
// USB receive packet buffer: two ping-pong banks shared between the USB receiver (writer)
// and the CPU (reader), with bank ownership as the only arbitration between the two ports.
module usb_rx_buffer_ctrl #(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned DROP_W = 8
) (
    input  logic                     clock48_i,
    input  logic                     reset_i,
    input  logic                     rx_start_i,
    input  logic                     rx_word_valid_i,
    input  logic [31:0]              rx_word_i,
    input  logic                     rx_end_i,
    input  logic                     rx_abort_i,
    input  logic [$clog2(DEPTH)-1:0] cpu_rd_addr_i,
    output logic [31:0]              cpu_rd_data_o,
    output logic                     packet_ready_o,
    output logic [$clog2(DEPTH):0]   packet_words_o,
    input  logic                     packet_release_i,
    output logic [DROP_W-1:0]        drop_count_o,
    output logic                     overflow_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);
    localparam logic [AW:0] CntOne  = (AW+1)'(1);

    typedef enum logic [1:0] {StIdle, StWrite, StDiscard} rx_st_e;
    typedef enum logic [1:0] {BkFree, BkFill, BkHeld} bank_st_e;

    rx_st_e            st_q, st_d;
    bank_st_e          bank_q [2];
    bank_st_e          bank_d [2];
    logic              cur_q, cur_d;
    logic [AW:0]       wr_cnt_q, wr_cnt_d;
    logic [AW:0]       len_q [2];
    logic [AW:0]       len_d [2];
    logic              rdyq_q [2];
    logic              rdyq_d [2];
    logic [1:0]        rdyq_cnt_q, rdyq_cnt_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              ovf_q, ovf_d;
    logic [31:0]       rd_data_q;
    logic [31:0]       mem_q [2*DEPTH];

    logic              mem_we;
    logic [AW:0]       mem_waddr;
    logic [AW:0]       cnt_inc;
    logic [AW:0]       fin_cnt;

    always_comb begin
        st_d       = st_q;
        bank_d     = bank_q;
        cur_d      = cur_q;
        wr_cnt_d   = wr_cnt_q;
        len_d      = len_q;
        rdyq_d     = rdyq_q;
        rdyq_cnt_d = rdyq_cnt_q;
        drop_d     = drop_q;
        ovf_d      = ovf_q;
        mem_we     = 1'b0;
        mem_waddr  = {cur_q, wr_cnt_q[AW-1:0]};
        cnt_inc    = wr_cnt_q + CntOne;
        fin_cnt    = wr_cnt_q;

        if (packet_release_i && (rdyq_cnt_q != 2'd0)) begin
            bank_d[rdyq_q[0]] = BkFree;
            rdyq_d[0]         = rdyq_q[1];
            rdyq_cnt_d        = rdyq_cnt_q - 2'd1;
        end

        // Allocation looks at bank_q, so a bank released this cycle is not reused until next cycle.
        unique case (st_q)
            StIdle, StDiscard: begin
                if (rx_start_i) begin
                    wr_cnt_d = '0;
                    if (bank_q[0] == BkFree) begin
                        cur_d     = 1'b0;
                        bank_d[0] = BkFill;
                        st_d      = StWrite;
                    end else if (bank_q[1] == BkFree) begin
                        cur_d     = 1'b1;
                        bank_d[1] = BkFill;
                        st_d      = StWrite;
                    end else begin
                        st_d = StDiscard;
                        if (drop_q != '1) drop_d = drop_q + DROP_W'(1);
                    end
                end else if ((st_q == StDiscard) && (rx_end_i || rx_abort_i)) begin
                    st_d = StIdle;
                end
            end
            StWrite: begin
                if (rx_abort_i) begin
                    bank_d[cur_q] = BkFree;
                    st_d          = StIdle;
                end else if (rx_start_i) begin
                    wr_cnt_d = '0;
                end else begin
                    if (rx_word_valid_i) begin
                        if (wr_cnt_q == FullCnt) begin
                            bank_d[cur_q] = BkFree;
                            ovf_d         = 1'b1;
                            st_d          = rx_end_i ? StIdle : StDiscard;
                        end else begin
                            mem_we   = 1'b1;
                            wr_cnt_d = cnt_inc;
                            fin_cnt  = cnt_inc;
                        end
                    end
                    if (rx_end_i && (st_d == StWrite)) begin
                        st_d = StIdle;
                        if (fin_cnt == '0) begin
                            bank_d[cur_q] = BkFree;
                        end else begin
                            bank_d[cur_q]             = BkHeld;
                            len_d[cur_q]              = fin_cnt;
                            rdyq_d[rdyq_cnt_d[0]]     = cur_q;
                            rdyq_cnt_d                = rdyq_cnt_d + 2'd1;
                        end
                    end
                end
            end
            default: st_d = StIdle;
        endcase
    end

    always_ff @(posedge clock48_i or posedge reset_i) begin
        if (reset_i) begin
            st_q       <= StIdle;
            bank_q[0]  <= BkFree;
            bank_q[1]  <= BkFree;
            cur_q      <= 1'b0;
            wr_cnt_q   <= '0;
            len_q[0]   <= '0;
            len_q[1]   <= '0;
            rdyq_q[0]  <= 1'b0;
            rdyq_q[1]  <= 1'b0;
            rdyq_cnt_q <= 2'd0;
            drop_q     <= '0;
            ovf_q      <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            st_q       <= st_d;
            bank_q     <= bank_d;
            cur_q      <= cur_d;
            wr_cnt_q   <= wr_cnt_d;
            len_q      <= len_d;
            rdyq_q     <= rdyq_d;
            rdyq_cnt_q <= rdyq_cnt_d;
            drop_q     <= drop_d;
            ovf_q      <= ovf_d;
            rd_data_q  <= mem_q[{rdyq_q[0], cpu_rd_addr_i}];
        end
    end

    // Packet storage carries no reset; contents are only meaningful for HELD banks.
    always_ff @(posedge clock48_i) begin
        if (mem_we) mem_q[mem_waddr] <= rx_word_i;
    end

    assign cpu_rd_data_o  = rd_data_q;
    assign packet_ready_o = (rdyq_cnt_q != 2'd0);
    assign packet_words_o = packet_ready_o ? len_q[rdyq_q[0]] : '0;
    assign drop_count_o   = drop_q;
    assign overflow_o     = ovf_q;

endmodule

// File: tb/tb_usb_rx_buffer_ctrl.sv
// Directed bench for usb_rx_buffer_ctrl: single/back-to-back packets, drops, overflow,
// aborts and mid-packet reset, each checked against hand-computed values.
module tb_usb_rx_buffer_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_start = 1'b0;
    logic        rx_word_valid = 1'b0;
    logic [31:0] rx_word = '0;
    logic        rx_end = 1'b0;
    logic        rx_abort = 1'b0;
    logic [4:0]  cpu_rd_addr = '0;
    logic [31:0] cpu_rd_data;
    logic        packet_ready;
    logic [5:0]  packet_words;
    logic        packet_release = 1'b0;
    logic [7:0]  drop_count;
    logic        overflow;

    int tests = 0;
    int fails = 0;

    usb_rx_buffer_ctrl #(.DEPTH(32), .DROP_W(8)) dut (
        .clock48_i       (clk),
        .reset_i         (rst),
        .rx_start_i      (rx_start),
        .rx_word_valid_i (rx_word_valid),
        .rx_word_i       (rx_word),
        .rx_end_i        (rx_end),
        .rx_abort_i      (rx_abort),
        .cpu_rd_addr_i   (cpu_rd_addr),
        .cpu_rd_data_o   (cpu_rd_data),
        .packet_ready_o  (packet_ready),
        .packet_words_o  (packet_words),
        .packet_release_i(packet_release),
        .drop_count_o    (drop_count),
        .overflow_o      (overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_pkt(input int n, input logic [31:0] base);
        rx_start = 1'b1;
        step();
        rx_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            rx_word_valid = 1'b1;
            rx_word       = base + 32'(i);
            step();
        end
        rx_word_valid = 1'b0;
        rx_end        = 1'b1;
        step();
        rx_end = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        cpu_rd_addr = addr;
        step();
        chk(tag, cpu_rd_data, exp);
    endtask

    task automatic release_pkt();
        packet_release = 1'b1;
        step();
        packet_release = 1'b0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ready"}, 32'(packet_ready), 32'd0);
        chk({tag, "_words"}, 32'(packet_words), 32'd0);
        chk({tag, "_rdata"}, cpu_rd_data, 32'd0);
        chk({tag, "_drop"}, 32'(drop_count), 32'd0);
        chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) step();
        chk_reset_outs("reset");
        rst = 1'b0;
        step();

        // Single packet
        send_pkt(5, 32'h1);
        chk("t1_ready", 32'(packet_ready), 32'd1);
        chk("t1_words", 32'(packet_words), 32'd5);
        for (int i = 0; i < 5; i++) read_chk("t1_read", 5'(i), 32'(i + 1));
        release_pkt();
        chk("t1_rel_ready", 32'(packet_ready), 32'd0);

        // Back-to-back packets, no release in between
        send_pkt(3, 32'hA0);
        send_pkt(4, 32'hB0);
        chk("t2_words_a", 32'(packet_words), 32'd3);
        read_chk("t2_read_a", 5'd2, 32'hA2);
        release_pkt();
        chk("t2_ready_b", 32'(packet_ready), 32'd1);
        chk("t2_words_b", 32'(packet_words), 32'd4);
        read_chk("t2_read_b", 5'd3, 32'hB3);
        release_pkt();
        chk("t2_empty", 32'(packet_ready), 32'd0);

        // Overflow: DEPTH+1 words then rx_end
        send_pkt(33, 32'h100);
        chk("t4_ovf", 32'(overflow), 32'd1);
        chk("t4_ready", 32'(packet_ready), 32'd0);
        chk("t4_drop", 32'(drop_count), 32'd0);
        send_pkt(2, 32'hC0);
        chk("t4_next_words", 32'(packet_words), 32'd2);
        read_chk("t4_next_read", 5'd1, 32'hC1);
        release_pkt();

        // Abort after 3 words, then rx_end together with rx_abort
        rx_start = 1'b1;
        step();
        rx_start      = 1'b0;
        rx_word_valid = 1'b1;
        rx_word       = 32'h77;
        repeat (3) step();
        rx_word_valid = 1'b0;
        rx_abort      = 1'b1;
        step();
        rx_abort = 1'b0;
        chk("t5_abort_ready", 32'(packet_ready), 32'd0);
        rx_start = 1'b1;
        step();
        rx_start      = 1'b0;
        rx_word_valid = 1'b1;
        repeat (2) step();
        rx_word_valid = 1'b0;
        rx_end        = 1'b1;
        rx_abort      = 1'b1;
        step();
        rx_end   = 1'b0;
        rx_abort = 1'b0;
        chk("t5_endabort_ready", 32'(packet_ready), 32'd0);
        chk("t5_drop", 32'(drop_count), 32'd0);
        send_pkt(4, 32'hD0);
        chk("t5_reuse_words", 32'(packet_words), 32'd4);
        read_chk("t5_reuse_read", 5'd3, 32'hD3);
        release_pkt();

        // Both banks held: third packet dropped, counter saturates
        send_pkt(3, 32'hE0);
        send_pkt(4, 32'hF0);
        send_pkt(2, 32'h55);
        chk("t3_drop1", 32'(drop_count), 32'd1);
        chk("t3_head_words", 32'(packet_words), 32'd3);
        read_chk("t3_head_read", 5'd0, 32'hE0);
        for (int i = 0; i < 254; i++) begin
            rx_start = 1'b1;
            step();
            rx_start = 1'b0;
            rx_end   = 1'b1;
            step();
            rx_end = 1'b0;
        end
        chk("t3_drop255", 32'(drop_count), 32'd255);
        send_pkt(1, 32'h66);
        chk("t3_drop_sat", 32'(drop_count), 32'd255);
        chk("t3_queue_kept", 32'(packet_words), 32'd3);
        release_pkt();
        chk("t3_words_b", 32'(packet_words), 32'd4);
        read_chk("t3_read_b", 5'd1, 32'hF1);
        release_pkt();
        chk("t3_empty", 32'(packet_ready), 32'd0);

        // Reset mid-packet with a packet already held
        send_pkt(2, 32'h90);
        chk("t6_pre_ready", 32'(packet_ready), 32'd1);
        rx_start = 1'b1;
        step();
        rx_start      = 1'b0;
        rx_word_valid = 1'b1;
        rx_word       = 32'h33;
        repeat (2) step();
        rst = 1'b1;
        #1;
        chk_reset_outs("t6_async");
        step();
        rst = 1'b0;
        repeat (3) step();
        rx_word_valid = 1'b0;
        rx_end        = 1'b1;
        step();
        rx_end = 1'b0;
        chk("t6_ready_after", 32'(packet_ready), 32'd0);
        step();
        chk("t6_ready_later", 32'(packet_ready), 32'd0);
        chk("t6_ovf_after", 32'(overflow), 32'd0);
        send_pkt(1, 32'hEE);
        chk("t6_fresh_words", 32'(packet_words), 32'd1);
        read_chk("t6_fresh_read", 5'd0, 32'hEE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
